// File: rtl/event_queue_x4.sv
// Event capture FIFO behind the 4-input priority encoder: detects new request
// events (flag rise or priority change), queues their codes, drains via valid/ready.
module event_queue_x4 #(
    parameter int DEPTH = 4,
    parameter int CW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CW-1:0]           code_in,
    input  logic                    flag_in,
    input  logic                    ready,
    input  logic                    ovf_clr,
    output logic [CW-1:0]           out,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [CW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count_q;
    logic            overflow_q;
    logic            prev_flag;
    logic [CW-1:0]   prev_code;

    logic evt;
    logic push_req;
    logic pop;
    logic push;
    logic drop;

    // A falling flag is never an event; a code change under a held flag is.
    assign evt      = flag_in & (~prev_flag | (code_in != prev_code));
    assign push_req = enable & evt;
    assign pop      = valid & ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign valid    = ~empty;
    assign out      = empty ? '0 : mem[rd_ptr];
    assign overflow = overflow_q;
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_flag <= 1'b0;
            prev_code <= '0;
        end else begin
            prev_flag <= flag_in;
            prev_code <= code_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear keeps the bit set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= code_in;
        end
    end

endmodule

// File: tb/tb_event_queue_x4.sv
// Self-checking bench for event_queue_x4: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_event_queue_x4;

    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [CW-1:0] code_in = '0;
    logic          flag_in = 1'b0;
    logic          ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [CW-1:0] out;
    logic          valid;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [CW-1:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          m_pflag = 1'b0;
    logic [CW-1:0] m_pcode = '0;

    event_queue_x4 #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .code_in(code_in),
        .flag_in(flag_in), .ready(ready), .ovf_clr(ovf_clr), .out(out),
        .valid(valid), .full(full), .empty(empty), .overflow(overflow),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] m_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Advance the model with the current inputs, then step one clock.
    task automatic tick();
        bit ev, preq, pp, was_full;
        if (reset) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_pflag = 1'b0;
            m_pcode = '0;
        end else begin
            ev       = flag_in && (!m_pflag || code_in != m_pcode);
            preq     = enable && ev;
            pp       = (mq.size() > 0) && ready;
            was_full = (mq.size() == DEPTH);
            if (preq && was_full && !pp) m_ovf = 1'b1;
            else if (ovf_clr)            m_ovf = 1'b0;
            if (pp) void'(mq.pop_front());
            if (preq && (!was_full || pp)) mq.push_back(code_in);
            m_pflag = flag_in;
            m_pcode = code_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flag_in = 1'b0; code_in = '0; ready = 1'b0;
        ovf_clr = 1'b0; enable = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flag_in = 1'b1; code_in = 2'd1;
        tick(); tick();
        reset = 1'b0; code_in = 2'd2;
        checks++;
        if (valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || out !== 2'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b empty=%b count=%0d out=%0d ovf=%b, want 0 1 0 0 0",
                     valid, empty, count, out, overflow);
        end
        tick();
        flag_in = 1'b0;
        checks++;
        if (valid !== 1'b1 || out !== 2'd2) begin
            errors++;
            $display("FAIL first_event_after_reset: valid=%b out=%0d, want 1 2", valid, out);
        end
    endtask

    task automatic test_edge_detect();
        do_reset();
        flag_in = 1'b1; code_in = 2'd1;
        repeat (6) tick();
        code_in = 2'd3; tick();
        flag_in = 1'b0; tick();
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL edge_count: count=%0d want 2", count);
        end
        ready = 1'b1;
        checks++;
        if (out !== 2'd1) begin
            errors++;
            $display("FAIL edge_drain0: out=%0d want 1", out);
        end
        tick();
        checks++;
        if (out !== 2'd3) begin
            errors++;
            $display("FAIL edge_drain1: out=%0d want 3", out);
        end
        tick();
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || out !== 2'd0) begin
            errors++;
            $display("FAIL edge_empty: valid=%b out=%0d want 0 0", valid, out);
        end
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        flag_in = 1'b1; code_in = 2'd0; tick();
        code_in = 2'd1; tick();
        flag_in = 1'b0; tick();
        flag_in = 1'b1; code_in = 2'd2; tick();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL enable_block: count=%0d want 0", count);
        end
        enable = 1'b1; tick(); tick();
        checks++;
        if (count !== 3'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_no_event: count=%0d valid=%b want 0 0", count, valid);
        end
        flag_in = 1'b0;
    endtask

    task automatic fill4();
        flag_in = 1'b1; ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            code_in = CW'(k);
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [CW-1:0] exp_seq [4];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        fill4();
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: full=%b count=%0d ovf=%b want 1 4 0", full, count, overflow);
        end
        code_in = 2'd0; tick();
        flag_in = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_drop: ovf=%b count=%0d want 1 4", overflow, count);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_seq[i]) begin
                errors++;
                $display("FAIL ovf_drain%0d: out=%0d want %0d", i, out, exp_seq[i]);
            end
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [CW-1:0] exp_seq [4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd2};
        do_reset();
        fill4();
        code_in = 2'd2; ready = 1'b1; tick();
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d ovf=%b want 4 0", count, overflow);
        end
        ready = 1'b0; code_in = 2'd1; ovf_clr = 1'b1; tick();
        ovf_clr = 1'b0; flag_in = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: ovf=%b want 1", overflow);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_seq[i]) begin
                errors++;
                $display("FAIL fpp_drain%0d: out=%0d want %0d", i, out, exp_seq[i]);
            end
            tick();
        end
        ready = 1'b0; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [CW-1:0] c;
        do_reset();
        ready = 1'b1; flag_in = 1'b1; c = 2'd0;
        for (int i = 0; i < 10; i++) begin
            c = c + CW'(1 + $urandom_range(0, 2));
            code_in = c;
            tick();
            checks++;
            if (out !== c || count !== 3'd1) begin
                errors++;
                $display("FAIL wrap%0d: out=%0d count=%0d want %0d 1", i, out, count, c);
            end
        end
        ready = 1'b0;
        code_in = c + CW'(1); tick();
        code_in = c + CW'(2); tick();
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL midq_count: count=%0d want 3", count);
        end
        reset = 1'b1; code_in = c; tick();
        reset = 1'b0; flag_in = 1'b0;
        checks++;
        if (count !== 3'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL midq_reset: count=%0d valid=%b want 0 0", count, valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            enable  = ($urandom_range(0, 9) != 0);
            flag_in = ($urandom_range(0, 3) != 0);
            code_in = CW'($urandom);
            ready   = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (out !== m_head() || valid !== (mq.size() > 0) || count !== 3'(mq.size()) ||
                full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random%0d: out=%0d valid=%b count=%0d full=%b empty=%b ovf=%b want %0d %b %0d %b %b %b",
                         i, out, valid, count, full, empty, overflow, m_head(), mq.size() > 0,
                         mq.size(), mq.size() == DEPTH, mq.size() == 0, m_ovf);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_detect();
        test_enable();
        test_overflow();
        test_full_push_pop();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
